instr_mem_mp: RTL
=================

Name: instr_mem_mp

Overview:
- Parametrised successor to the single-port 18-bit instruction memory.
- Provides N_CORES independent synchronous read ports, one per processing core, so all cores fetch in parallel from one shared program store.
- Adds a runtime program-load path: a byte stream, e.g. from the UART receiver, is assembled into instruction words and written from address 0, replacing the hard-coded program.
- Sits between the core array (fetch side) and the host link (load side).

Parameters:
- INSTR_W, 18, instruction word width.
- ADDR_W, 12, address width.
- DEPTH, 4096, number of words; must be ≤ 2**ADDR_W.
- N_CORES, 4, number of read ports.
- NOP_WORD, 18'h1C000, power-on fill value and out-of-range read value (nop opcode 28, operand 0).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_en  in  N_CORES  per-port fetch request.
- rd_addr  in  N_CORES*ADDR_W  per-port address; port p uses bits [p*ADDR_W +: ADDR_W].
- instr_out  out  N_CORES*INSTR_W  per-port fetched instruction.
- instr_valid  out  N_CORES  per-port data-valid.
- ld_start  in  1  pulse that begins a program load.
- ld_len  in  ADDR_W+1  number of words to load, sampled on ld_start.
- ld_byte  in  8  load data byte.
- ld_byte_valid  in  1  byte present.
- ld_byte_ready  out  1  block accepts byte.
- loading  out  1  high while a load is in progress.
- load_done  out  1  one-cycle pulse at the end of a load.

Behaviour:
- Reset (rst_n low, asynchronous):
  - instr_out = all NOP_WORD, instr_valid = 0, ld_byte_ready = 0, loading = 0, load_done = 0.
  - FSM = IDLE; byte counter, word counter and write pointer = 0.
  - Memory array is NOT cleared by reset; it is initialised to NOP_WORD at configuration only.
- Read, each port independent:
  - rd_en[p] = 1 in cycle t while not loading → instr_out[p] = mem[rd_addr[p]] and instr_valid[p] = 1 in cycle t+1. Latency is 1.
  - rd_addr ≥ DEPTH returns NOP_WORD.
  - rd_en[p] = 0 → instr_valid[p] = 0 next cycle and instr_out[p] holds its last value.
  - Several ports on the same address all receive the same word in the same cycle.
- Load FSM states: IDLE, LOAD, DONE.
  - IDLE: ld_start = 1 latches len = min(ld_len, DEPTH) and clears counters.
    - If len = 0, go to DONE; otherwise go to LOAD.
    - ld_byte_valid in IDLE is ignored (ready = 0).
  - LOAD: loading = 1 and ld_byte_ready = 1.
    - A byte is accepted on ld_byte_valid & ld_byte_ready.
    - Bytes per word BPW = ceil(INSTR_W/8), which is 3 at default.
    - Bytes are little-endian: byte k fills bits [8k +: 8], and excess bits of the last byte are discarded.
    - On acceptance of byte BPW-1, the assembled word is written to mem[wr_ptr] on that clock edge, wr_ptr++, and the byte counter resets.
    - When the word count reaches len after that write, go to DONE; ready drops to 0 in the DONE cycle.
  - DONE: load_done = 1 for exactly one cycle, loading = 0, then return to IDLE.
  - ld_start asserted in LOAD or DONE is ignored.
- Reads during load:
  - While loading = 1, all rd_en are ignored and instr_valid = 0.
  - Reads resume the cycle after DONE, so the first valid data appears 1 cycle after that.
- Reset mid-load aborts immediately. Words already written are kept; any partially assembled word is discarded.
- Bytes stalled by ld_byte_valid = 0 simply extend LOAD; there is no timeout.

Test Plan:
- Reset, then rd_en = 4'b1111 with addresses 0, 1, 4095, 5 → next cycle all instr_out = 18'h1C000 and instr_valid = 4'b1111.
- ld_start with ld_len = 2; bytes 0x03, 0x40, 0x02, 0xFF, 0xFF, 0x03 → mem[0] = 18'h24003, mem[1] = 18'h3FFFF. load_done pulses once, 1 cycle after the 6th byte is accepted, and loading falls with it.
- During that load, hold rd_en = 4'b1111 → instr_valid stays 0. After DONE, port 2 reads addr 1 → 18'h3FFFF, 1 cycle later.
- Gapped byte stream (valid low 5 cycles between bytes) with ld_len = 1 → same resulting word, no extra writes. An ld_start mid-load is ignored and wr_ptr is not reset.
- ld_len = 0 → load_done 1 cycle after ld_start, memory unchanged. ld_len = 4097 → clamped, exactly 4096 words written.
- rst_n low after 4 of 6 bytes → mem[0] updated, mem[1] unchanged, FSM in IDLE, ld_byte_ready = 0 and all outputs at their reset values.

Source files
------------

// File: rtl/instr_mem_mp.sv
// Shared multi-port instruction store with a byte-stream program loader.
// N_CORES synchronous read ports; the loader writes words from address 0.
module instr_mem_mp #(
   parameter int                 INSTR_W  = 18,
   parameter int                 ADDR_W   = 12,
   parameter int                 DEPTH    = 4096,
   parameter int                 N_CORES  = 4,
   parameter logic [INSTR_W-1:0] NOP_WORD = 18'h1C000
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [N_CORES-1:0]         rd_en,
   input  logic [N_CORES*ADDR_W-1:0]  rd_addr,
   output logic [N_CORES*INSTR_W-1:0] instr_out,
   output logic [N_CORES-1:0]         instr_valid,
   input  logic                       ld_start,
   input  logic [ADDR_W:0]            ld_len,
   input  logic [7:0]                 ld_byte,
   input  logic                       ld_byte_valid,
   output logic                       ld_byte_ready,
   output logic                       loading,
   output logic                       load_done
);
   localparam int BPW = (INSTR_W + 7) / 8;
   localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
   localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic [BCW-1:0]   LAST_B  = BCW'(BPW - 1);

   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

   state_t                          state_q;
   logic [ADDR_W:0]                 len_q;
   logic [ADDR_W:0]                 wcnt_q;
   logic [ADDR_W-1:0]               wr_ptr_q;
   logic [BCW-1:0]                  bcnt_q;
   logic [8*(BPW-1)-1:0]            asm_q;
   logic                            loading_q;
   logic                            ready_q;
   logic                            done_q;
   logic [N_CORES-1:0][INSTR_W-1:0] instr_q;
   logic [N_CORES-1:0][INSTR_W-1:0] rdata_d;
   logic [N_CORES-1:0]              valid_q;
   logic [N_CORES-1:0][ADDR_W-1:0]  raddr;
   logic [ADDR_W:0]                 len_d;
   logic [ADDR_W:0]                 wcnt_d;
   logic [INSTR_W-1:0]              wr_word_d;
   logic                            rd_ok;
   logic                            byte_acc;
   logic                            last_b;
   logic                            we;

   // Filled with nops at configuration; reset deliberately leaves it alone.
   logic [INSTR_W-1:0] mem [DEPTH] = '{default: NOP_WORD};

   assign raddr     = rd_addr;
   assign len_d     = (ld_len > DEPTH_L) ? DEPTH_L : ld_len;
   assign wcnt_d    = wcnt_q + 1'b1;
   assign rd_ok     = (state_q == IDLE) && !ld_start;
   assign byte_acc  = ld_byte_valid && ready_q;
   assign last_b    = (bcnt_q == LAST_B);
   assign we        = byte_acc && last_b;
   // Last byte goes on top; bits above INSTR_W fall off here.
   assign wr_word_d = INSTR_W'({ld_byte, asm_q});

   always_comb begin
      rdata_d = '0;
      for (int p = 0; p < N_CORES; p++) begin
         if ({1'b0, raddr[p]} < DEPTH_L)
            rdata_d[p] = mem[raddr[p]];
         else
            rdata_d[p] = NOP_WORD;
      end
   end

   always_ff @(posedge clk) begin
      if (we)
         mem[wr_ptr_q] <= wr_word_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_q <= {N_CORES{NOP_WORD}};
         valid_q <= '0;
      end else begin
         for (int p = 0; p < N_CORES; p++) begin
            valid_q[p] <= rd_en[p] && rd_ok;
            if (rd_en[p] && rd_ok)
               instr_q[p] <= rdata_d[p];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         len_q     <= '0;
         wcnt_q    <= '0;
         wr_ptr_q  <= '0;
         bcnt_q    <= '0;
         asm_q     <= '0;
         loading_q <= 1'b0;
         ready_q   <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (ld_start) begin
                  len_q    <= len_d;
                  wcnt_q   <= '0;
                  wr_ptr_q <= '0;
                  bcnt_q   <= '0;
                  if (len_d == '0) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q   <= LOAD;
                     loading_q <= 1'b1;
                     ready_q   <= 1'b1;
                  end
               end
            end
            LOAD: begin
               if (byte_acc) begin
                  if (last_b) begin
                     bcnt_q   <= '0;
                     wcnt_q   <= wcnt_d;
                     wr_ptr_q <= wr_ptr_q + 1'b1;
                     if (wcnt_d == len_q) begin
                        state_q   <= DONE;
                        loading_q <= 1'b0;
                        ready_q   <= 1'b0;
                        done_q    <= 1'b1;
                     end
                  end else begin
                     asm_q[8*bcnt_q +: 8] <= ld_byte;
                     bcnt_q <= bcnt_q + 1'b1;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign instr_out     = instr_q;
   assign instr_valid   = valid_q;
   assign ld_byte_ready = ready_q;
   assign loading       = loading_q;
   assign load_done     = done_q;

endmodule
